// File: rtl/sobel_pkg.sv
// sobel_pkg: shared lane indices, memory-select codes and frame size for the Sobel write arbiter.
package sobel_pkg;
    typedef enum logic [1:0] {
        CSEL_NONE = 2'b00,
        CSEL_X    = 2'b01,
        CSEL_Y    = 2'b10,
        CSEL_COMB = 2'b11
    } csel_t;
    localparam logic [1:0] LANE_X = 2'd0;
    localparam logic [1:0] LANE_Y = 2'd1;
    localparam logic [1:0] LANE_C = 2'd2;
    localparam int PIX_CNT_DEF = 65536;
    localparam int CW_DEF = 17;
    function automatic logic [1:0] next_lane(input logic [1:0] l);
        return l == LANE_C ? LANE_X : l + 2'd1;
    endfunction
    function automatic csel_t lane_csel(input logic [1:0] l);
        return l == LANE_X ? CSEL_X : l == LANE_Y ? CSEL_Y : CSEL_COMB;
    endfunction
endpackage

// File: rtl/sobel_wr_arb_if.sv
// sobel_wr_arb_if: producer lanes, result-memory write port and frame control of the write arbiter.
interface sobel_wr_arb_if;
    logic x_valid, x_ready, y_valid, y_ready, c_valid, c_ready;
    logic [15:0] x_addr, y_addr, c_addr, caddr_wr;
    logic [7:0] x_data, y_data, c_data, cdata_wr;
    logic [1:0] csel;
    logic cwr, start, busy, frame_done;
    modport master (
        output x_valid, x_addr, x_data, y_valid, y_addr, y_data, c_valid, c_addr, c_data, start,
        input x_ready, y_ready, c_ready, cwr, csel, caddr_wr, cdata_wr, busy, frame_done
    );
    modport slave (
        input x_valid, x_addr, x_data, y_valid, y_addr, y_data, c_valid, c_addr, c_data, start,
        output x_ready, y_ready, c_ready, cwr, csel, caddr_wr, cdata_wr, busy, frame_done
    );
endinterface

// File: rtl/sobel_lane_hold.sv
// sobel_lane_hold: one-entry holding register for a producer lane; emptied by the arbiter grant.
module sobel_lane_hold (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [15:0] addr,
    input  logic [7:0]  data,
    input  logic        grant,
    output logic        ready,
    output logic        full,
    output logic [15:0] h_addr,
    output logic [7:0]  h_data
);
    assign ready = ~full;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            full <= 1'b0;
            h_addr <= '0;
            h_data <= '0;
        end else if (grant) begin
            full <= 1'b0;
        end else if (valid && !full) begin
            full <= 1'b1;
            h_addr <= addr;
            h_data <= data;
        end
endmodule

// File: rtl/sobel_wr_arb.sv
// sobel_wr_arb: arbitrates the result-memory write port between the X, Y and Combine lanes and tracks frame completion.
// Define SOBEL_ARB_FIXED_PRIO_EN for fixed X > Y > C priority instead of round-robin.
module sobel_wr_arb
    import sobel_pkg::*;
#(
    parameter int PIX_CNT = PIX_CNT_DEF,
    parameter int CW = CW_DEF
) (
    input logic clk,
    input logic reset,
    sobel_wr_arb_if.slave bus
);
    localparam logic [CW-1:0] PIX = CW'(PIX_CNT);
    logic [2:0] full, gnt;
    logic [15:0] h_addr [3];
    logic [7:0] h_data [3];
    logic [CW-1:0] cnt [3];
    logic [1:0] sel;
    logic any, done;

    sobel_lane_hold u_x (.clk, .reset, .valid(bus.x_valid), .addr(bus.x_addr), .data(bus.x_data),
        .grant(gnt[LANE_X]), .ready(bus.x_ready), .full(full[LANE_X]), .h_addr(h_addr[LANE_X]), .h_data(h_data[LANE_X]));
    sobel_lane_hold u_y (.clk, .reset, .valid(bus.y_valid), .addr(bus.y_addr), .data(bus.y_data),
        .grant(gnt[LANE_Y]), .ready(bus.y_ready), .full(full[LANE_Y]), .h_addr(h_addr[LANE_Y]), .h_data(h_data[LANE_Y]));
    sobel_lane_hold u_c (.clk, .reset, .valid(bus.c_valid), .addr(bus.c_addr), .data(bus.c_data),
        .grant(gnt[LANE_C]), .ready(bus.c_ready), .full(full[LANE_C]), .h_addr(h_addr[LANE_C]), .h_data(h_data[LANE_C]));

`ifdef SOBEL_ARB_FIXED_PRIO_EN
    assign sel = full[LANE_X] ? LANE_X : full[LANE_Y] ? LANE_Y : LANE_C;
`else
    // nxt is the lane the search starts from: the one after the last grant
    logic [1:0] nxt, l1, l2;
    assign l1 = next_lane(nxt);
    assign l2 = next_lane(l1);
    assign sel = full[nxt] ? nxt : full[l1] ? l1 : l2;
    always_ff @(posedge clk or negedge reset)
        if (!reset) nxt <= LANE_X;
        else if (any) nxt <= next_lane(sel);
`endif

    assign any = |full;
    assign gnt = any ? 3'b001 << sel : 3'b000;
    assign done = bus.busy && cnt[0] == PIX && cnt[1] == PIX && cnt[2] == PIX;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            bus.cwr <= 1'b0;
            bus.csel <= CSEL_NONE;
            bus.caddr_wr <= '0;
            bus.cdata_wr <= '0;
        end else begin
            bus.cwr <= any;
            bus.csel <= any ? lane_csel(sel) : CSEL_NONE;
            if (any) begin
                bus.caddr_wr <= h_addr[sel];
                bus.cdata_wr <= h_data[sel];
            end
        end

    // start overrides both completion and counting of a coincident grant
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            bus.busy <= 1'b0;
            bus.frame_done <= 1'b0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            bus.frame_done <= done && !bus.start;
            bus.busy <= bus.start ? 1'b1 : done ? 1'b0 : bus.busy;
            for (int i = 0; i < 3; i++)
                cnt[i] <= (bus.start || done) ? '0 : (gnt[i] && cnt[i] != PIX) ? cnt[i] + CW'(1) : cnt[i];
        end
endmodule

// File: doc/sobel_wr_arb.md
Name: sobel_wr_arb

Overview:
- Arbitrates the single result-memory write port (cwr/csel/caddr_wr/cdata_wr) between three Sobel result producers: X gradient, Y gradient and Combine.
- Each producer has a valid/ready lane with a one-entry holding register.
- Grants are round-robin, one write per cycle.
- Counts writes per lane and flags frame completion back to the top-level controller (busy/done).

Parameters:
- PIX_CNT, 65536: writes per lane per frame (256x256 output map).
- CW, 17: lane write-counter width; must satisfy 2^CW > PIX_CNT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: clear counters, raise busy.
- x_valid  in  1  X lane has a result.
- x_ready  out  1  X holding register empty.
- x_addr  in  16  X result address.
- x_data  in  8  X result, already clamped to 0..255.
- y_valid, y_ready, y_addr, y_data: as the X lane, for the Y lane.
- c_valid, c_ready, c_addr, c_data: as the X lane, for the Combine lane.
- cwr  out  1  memory write strobe.
- csel  out  2  memory select: 01 = X, 10 = Y, 11 = Combine, 00 = idle.
- caddr_wr  out  16  write address.
- cdata_wr  out  8  write data.
- busy  out  1  high from start until frame done.
- frame_done  out  1  one-cycle pulse once all lanes have written PIX_CNT.

Behaviour:
- Reset (reset=0, async):
  - cwr=0, csel=00, caddr_wr=0, cdata_wr=0, busy=0, frame_done=0.
  - All holds empty, so x/y/c_ready=1.
  - Counters 0; round-robin pointer points at X.
- Lane handshake:
  - Transfer when valid && ready; ready = hold empty, driven from a register with no combinational path from valid.
  - On transfer, addr/data are latched and the hold goes full.
  - Producers hold valid/addr/data stable until ready.
- Arbitration (each cycle):
  - Candidates are the full holds.
  - Search order starts at the lane after the last granted (X→Y→C→X).
  - Exactly one grant per cycle if any hold is full.
  - On the granted lane, the next edge empties the hold and registers cwr=1, csel=lane code, caddr_wr and cdata_wr.
- Idle cycle: cwr=0 and csel=00; caddr_wr/cdata_wr keep their last values.
- Latency:
  - Handshake at edge k → cwr at edge k+1 when uncontended.
  - Worst case with all lanes full: edge k+3.
- Throughput:
  - The hold re-opens the cycle after its grant, so one lane alone sustains 1 write / 2 cycles.
  - Three saturated lanes sustain 1 write / cycle total.
- Simultaneous accept and grant on the same lane is impossible: a full hold blocks accept.
- Counters:
  - Per-lane cnt_x/cnt_y/cnt_c increment on each granted write; they saturate at PIX_CNT and do not wrap.
  - A lane that is already at PIX_CNT still gets its writes to memory, but they are not counted.
- Frame done:
  - When all three counters equal PIX_CNT and busy=1: frame_done pulses for 1 cycle on the next edge, busy←0, counters←0.
- start:
  - Sets busy=1 and clears counters.
  - If start coincides with a counted grant, start wins: the counter goes to 0 and the write itself still occurs.
  - If start coincides with the completion condition, frame_done is suppressed.
  - start while busy restarts counting.
- Async reset mid-frame: pending holds are discarded with no partial write; cwr falls immediately.

Optional Feature:
- SOBEL_ARB_FIXED_PRIO_EN
  - Defined: fixed priority X > Y > C; round-robin pointer removed.
  - Undefined (default): round-robin as above.

Decomposition:
- Package sobel_pkg holds:
  - csel codes: CSEL_NONE=2'b00, CSEL_X=2'b01, CSEL_Y=2'b10, CSEL_COMB=2'b11.
  - Lane index constants LANE_X=0, LANE_Y=1, LANE_C=2.
  - Default PIX_CNT.
- One sub-module is natural: sobel_lane_hold (valid/ready hold register with clear on grant), instantiated three times.

Test Plan:
- Reset:
  - Stimulus: reset=0 mid-activity with X hold full.
  - Required: cwr=0 and csel=00 immediately; x_ready=1 after release; no write of the held data.
- Single lane:
  - Stimulus: x_valid with addr 0x0010, data 0x7F, handshake at edge k.
  - Required: edge k+1 gives cwr=1, csel=01, caddr_wr=0x0010, cdata_wr=0x7F; edge k+2 gives cwr=0.
- Contention:
  - Stimulus: all three lanes loaded in the same cycle.
  - Required: three consecutive writes with csel 01, 10, 11.
  - Second round, with the pointer after C: order 01, 10, 11 again.
  - With SOBEL_ARB_FIXED_PRIO_EN and X continuously valid: Y/C are granted only on cycles when X's hold is empty.
- Frame completion:
  - Setup: PIX_CNT=4; start, then four writes per lane interleaved.
  - Required: frame_done one-cycle pulse 1 edge after the 12th write; busy falls; counters 0.
- Start collision:
  - Stimulus: start asserted in the same cycle as the final counted write.
  - Required: no frame_done; busy stays 1; counters 0.
- Saturation:
  - Stimulus: a fifth X write before Y/C complete (PIX_CNT=4).
  - Required: the write appears on cwr; cnt_x stays 4; frame_done still fires once after Y/C finish.
